// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} buffer that parks a response accepted while frozen.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              capture pc_in/instr_in and mark the entry valid
//   clear             drop the entry (wins over load)
//   pc_in, instr_in   data to capture
//   valid, pc, instr  stored entry
module if_skid_buf
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= INSTR_W'(NOP_INSTR);
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues fetches over a req/valid
// handshake tolerant of wait states, and drives the IF/ID register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   freeze, flush            stall IF/ID and PC / insert a bubble
//   branch_taken, branch_addr  redirect the PC (low two bits ignored)
//   imem_req, imem_addr      fetch request and address (registered)
//   imem_valid, imem_rdata   fetch response
//   if_valid, if_pc, if_instr  IF/ID register (if_pc = fetch address + 4)
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  if_state_e          state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, pc_inc, target;
  logic               req_n;
  logic [ADDR_W-1:0]  addr_n;
  logic               ifv_n;
  logic [ADDR_W-1:0]  ifpc_n;
  logic [INSTR_W-1:0] ifi_n;
  logic               bubble;
  logic               buf_load, buf_clear, buf_valid;
  logic [ADDR_W-1:0]  buf_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic               unused_low_bits;

  // Branch targets are word aligned; the low address bits are dropped.
  assign target          = {branch_addr[ADDR_W-1:2], 2'b00};
  assign unused_low_bits = ^branch_addr[1:0];
  assign pc_inc          = pc + ADDR_W'(PC_STEP);

  if_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .pc_in    (pc_inc),
    .instr_in (imem_rdata),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // PC, fetch request and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      imem_req  <= 1'b0;
      imem_addr <= PC_RESET;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_instr  <= INSTR_W'(NOP_INSTR);
    end else begin
      pc        <= pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      if_valid  <= ifv_n;
      if_pc     <= ifpc_n;
      if_instr  <= ifi_n;
    end
  end

  // Next-state, PC and IF/ID update
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    ifv_n     = if_valid;
    ifpc_n    = if_pc;
    ifi_n     = if_instr;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    bubble    = 1'b0;

    case (state)
      IDLE: state_n = WAIT;
      WAIT: begin
        if (imem_valid) begin
          pc_n = pc_inc;
          if (freeze) begin
            buf_load = 1'b1;
            state_n  = HOLD;
          end else begin
            ifv_n  = 1'b1;
            ifpc_n = pc_inc;
            ifi_n  = imem_rdata;
          end
        end else if (!freeze) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (!freeze) begin
          ifv_n     = buf_valid;
          ifpc_n    = buf_pc;
          ifi_n     = buf_instr;
          buf_clear = 1'b1;
          state_n   = WAIT;
        end
      end
      KILL: begin
        bubble = 1'b1;
        if (imem_valid) state_n = WAIT;
      end
      default: state_n = IDLE;
    endcase

    if (branch_taken) begin
      pc_n      = target;
      bubble    = 1'b1;
      buf_load  = 1'b0;
      buf_clear = 1'b1;
      // An outstanding fetch must complete before the target can be issued;
      // if it completes this very cycle the target goes out next cycle.
      case (state)
        WAIT, KILL: state_n = imem_valid ? WAIT : KILL;
        default:    state_n = WAIT;
      endcase
    end else if (flush) begin
      bubble = 1'b1;
    end

    if (bubble) begin
      ifv_n  = 1'b0;
      ifpc_n = '0;
      ifi_n  = INSTR_W'(NOP_INSTR);
    end

    // In KILL the stale request stays on the bus untouched.
    req_n  = (state_n == WAIT) || (state_n == KILL);
    addr_n = (state_n == KILL) ? imem_addr : pc_n;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush, branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Memory model: instr = addr, ws wait states, optional stray response
  int unsigned ws    = 0;
  logic [7:0]  cnt   = '0;
  logic        stray = 1'b0;

  assign imem_valid = stray || (imem_req && (cnt == 8'(ws)));
  assign imem_rdata = stray ? 32'hDEAD_BEEF : imem_addr;

  always @(posedge clk) begin
    if (!imem_req || imem_valid) cnt <= '0;
    else                         cnt <= cnt + 8'd1;
  end

  always #5 clk = ~clk;

  if_fetch_ctrl #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .PC_RESET (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    for (int i = 0; i < int'(n); i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_addr = '0; rst = 1'b1;

    // ---- Run 1: streaming, freeze, branch+flush, flush, wrap ----
    ws = 0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr,         32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc",    if_pc,             32'h0);
    chk("rst_instr", if_instr,          32'h0);
    rst = 1'b0;

    tick(); // IDLE -> WAIT
    chk("idle_req",   {31'b0, imem_req}, 32'd1);
    chk("idle_addr",  imem_addr,         32'h0);
    chk("idle_valid", {31'b0, if_valid}, 32'd0);

    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("strm_valid", {31'b0, if_valid}, 32'd1);
      chk("strm_pc",    if_pc,             32'(4 * k));
      chk("strm_instr", if_instr,          32'(4 * (k - 1)));
    end
    chk("strm_addr", imem_addr, 32'h10);

    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_req",   {31'b0, imem_req}, 32'd0);
      chk("frz_valid", {31'b0, if_valid}, 32'd1);
      chk("frz_pc",    if_pc,             32'h10);
      chk("frz_instr", if_instr,          32'h0C);
    end
    freeze = 1'b0;
    tick();
    chk("unfrz_pc",    if_pc,    32'h14);
    chk("unfrz_instr", if_instr, 32'h10);
    chk("unfrz_addr",  imem_addr, 32'h14);
    tick();
    chk("unfrz2_pc",    if_pc,    32'h18);
    chk("unfrz2_instr", if_instr, 32'h14);

    branch_taken = 1'b1; flush = 1'b1; branch_addr = 32'h103;
    tick();
    branch_taken = 1'b0; flush = 1'b0;
    chk("br_valid", {31'b0, if_valid}, 32'd0);
    chk("br_instr", if_instr,          32'h0);
    chk("br_addr",  imem_addr,         32'h100);
    tick();
    chk("br2_valid", {31'b0, if_valid}, 32'd1);
    chk("br2_pc",    if_pc,             32'h104);
    chk("br2_instr", if_instr,          32'h100);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'b0, if_valid}, 32'd0);
    chk("fl_addr",  imem_addr,         32'h108);
    tick();
    chk("fl2_pc",    if_pc,    32'h10C);
    chk("fl2_instr", if_instr, 32'h108);

    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_valid", {31'b0, if_valid}, 32'd1);
    chk("wrap_pc",    if_pc,             32'h0);
    chk("wrap_instr", if_instr,          32'hFFFF_FFFC);
    chk("wrap_next",  imem_addr,         32'h0);

    // ---- Run 2: redirect while frozen in HOLD ----
    ws = 0;
    do_reset(3);
    tick(); tick(); tick();
    chk("h_pc", if_pc, 32'h8);
    freeze = 1'b1;
    tick();
    chk("h_req",   {31'b0, imem_req}, 32'd0);
    chk("h_valid", {31'b0, if_valid}, 32'd1);
    chk("h_pc2",   if_pc,             32'h8);
    branch_taken = 1'b1; branch_addr = 32'h40;
    tick();
    branch_taken = 1'b0; freeze = 1'b0;
    chk("hb_valid", {31'b0, if_valid}, 32'd0);
    chk("hb_req",   {31'b0, imem_req}, 32'd1);
    chk("hb_addr",  imem_addr,         32'h40);
    tick();
    chk("hb2_valid", {31'b0, if_valid}, 32'd1);
    chk("hb2_pc",    if_pc,             32'h44);
    chk("hb2_instr", if_instr,          32'h40);

    // ---- Run 3: redirect during a wait-state fetch, then reset mid-fetch ----
    ws = 3;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    branch_taken = 1'b1; branch_addr = 32'h20;
    tick(); // IDLE redirect -> WAIT on 0x20
    chk("k_addr0", imem_addr,         32'h20);
    chk("k_req0",  {31'b0, imem_req}, 32'd1);
    branch_addr = 32'h200;
    tick(); // redirect with request outstanding -> KILL
    branch_taken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("k_addr",  imem_addr,         32'h20);
      chk("k_req",   {31'b0, imem_req}, 32'd1);
      chk("k_valid", {31'b0, if_valid}, 32'd0);
      tick();
    end
    chk("k_after_addr",  imem_addr,         32'h200);
    chk("k_after_valid", {31'b0, if_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("k_wait_valid", {31'b0, if_valid}, 32'd0);
    end
    tick();
    chk("k_got_valid", {31'b0, if_valid}, 32'd1);
    chk("k_got_pc",    if_pc,             32'h204);
    chk("k_got_instr", if_instr,          32'h200);
    chk("k_got_addr",  imem_addr,         32'h204);

    tick(); // one cycle into the fetch of 0x204
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_req",   {31'b0, imem_req}, 32'd0);
    chk("mrst_valid", {31'b0, if_valid}, 32'd0);
    chk("mrst_addr",  imem_addr,         32'h0);
    chk("mrst_pc",    if_pc,             32'h0);
    chk("mrst_instr", if_instr,          32'h0);
    stray = 1'b1; // late response arriving in IDLE
    tick();
    stray = 1'b0;
    ws = 0;
    chk("late_valid", {31'b0, if_valid}, 32'd0);
    chk("late_instr", if_instr,          32'h0);
    chk("late_req",   {31'b0, imem_req}, 32'd1);
    chk("late_addr",  imem_addr,         32'h0);
    tick();
    chk("post_valid", {31'b0, if_valid}, 32'd1);
    chk("post_pc",    if_pc,             32'h4);
    chk("post_instr", if_instr,          32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
